// File: rtl/sparc_ctrl_pkg.sv
// Shared definitions for the SPARC-subset control unit: state encoding,
// instruction field constants, datapath mux encodings and trap causes.
package sparc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_INIT    = 4'd1,
        ST_F_ADDR  = 4'd2,
        ST_F_WAIT  = 4'd3,
        ST_F_IR    = 4'd4,
        ST_DECODE  = 4'd5,
        ST_ALU     = 4'd6,
        ST_LS_ADDR = 4'd7,
        ST_L_WAIT  = 4'd8,
        ST_L_WB    = 4'd9,
        ST_S_DATA  = 4'd10,
        ST_S_WAIT  = 4'd11,
        ST_BRANCH  = 4'd12,
        ST_CALL    = 4'd13,
        ST_ADV     = 4'd14,
        ST_TRAP    = 4'd15
    } state_e;

    // Instruction format fields: op = IR[31:30], op2 = IR[24:22], op3 = IR[24:19]
    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;
    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [5:0] OP3_LD    = 6'h00;
    localparam logic [5:0] OP3_ST    = 6'h04;
    localparam logic [5:0] OP3_ADD   = 6'h00;
    localparam logic [5:0] OP3_ALU_LIMIT = 6'h38;

    // Datapath mux encodings
    localparam logic [1:0] NPC_SEL_INC    = 2'd0;
    localparam logic [1:0] NPC_SEL_TBR    = 2'd1;
    localparam logic [1:0] NPC_SEL_BRANCH = 2'd2;
    localparam logic [1:0] NPC_SEL_ALU    = 2'd3;
    localparam logic [1:0] CIN_SEL_PC     = 2'd0;
    localparam logic [1:0] CIN_SEL_NPC    = 2'd1;
    localparam logic [1:0] CIN_SEL_ALU    = 2'd2;
    localparam logic [1:0] CIN_SEL_MDR    = 2'd3;
    localparam logic [1:0] RC_SEL_RD      = 2'd0;
    localparam logic [1:0] RC_SEL_R15     = 2'd3;
    localparam logic       MAR_SEL_PC     = 1'b1;
    localparam logic       MAR_SEL_ALU    = 1'b0;
    localparam logic       MDR_SEL_RF     = 1'b1;
    localparam logic       MDR_SEL_RAM    = 1'b0;
    localparam logic       RA_SEL_RD      = 1'b1;
    localparam logic       RA_SEL_RS1     = 1'b0;
    localparam logic       OPSEL_OP1      = 1'b1;
    localparam logic       OPSEL_IR       = 1'b0;

    // Sticky trap cause codes
    localparam logic [1:0] TRAP_NONE        = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

    // Complete control word presented to the datapath
    typedef struct packed {
        logic       ire;
        logic       mdre;
        logic       mare;
        logic       npce;
        logic       pce;
        logic       psre;
        logic       rfe;
        logic       tbre;
        logic       wime;
        logic       mfa;
        logic       mop_sel;
        logic       mar_sel;
        logic       mdr_sel;
        logic       ra_sel;
        logic       aop_sel;
        logic       baux;
        logic       dispsel;
        logic       npc_add;
        logic       npc_addsel;
        logic       tb_add;
        logic       ttaux;
        logic       clr_pc;
        logic [1:0] npc_sel;
        logic [1:0] alu_sel;
        logic [1:0] cin_sel;
        logic [1:0] rc_sel;
        logic [5:0] op1;
    } ctrl_t;

    // States in which the unit is waiting for MFC
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_F_WAIT) || (s == ST_L_WAIT) || (s == ST_S_WAIT);
    endfunction

endpackage

// File: rtl/mfc_timeout_counter.sv
// Counts MFC-less wait cycles; flags expiry on the last permitted cycle so
// the control FSM can divert to the memory-timeout trap.
module mfc_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear has priority so the count always starts at zero on wait entry
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/sparc_control_unit.sv
// Microsequenced control unit: registered state machine stepping through
// fetch, decode and execute, with Moore-decoded datapath controls.
module sparc_control_unit
    import sparc_ctrl_pkg::*;
#(
    parameter int unsigned MFC_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        MFC,
    input  logic        cond_true,
    output logic        IRE,
    output logic        MDRE,
    output logic        MARE,
    output logic        nPCE,
    output logic        PCE,
    output logic        PSRE,
    output logic        RFE,
    output logic        TBRE,
    output logic        WIME,
    output logic        MFA,
    output logic        MOP_SEL,
    output logic        MAR_SEL,
    output logic        MDR_SEL,
    output logic        RA_SEL,
    output logic        AOP_SEL,
    output logic        BAUX,
    output logic        DISPSEL,
    output logic        nPC_ADD,
    output logic        nPC_ADDSEL,
    output logic        TB_ADD,
    output logic        ttAUX,
    output logic        ClrPC,
    output logic [1:0]  nPC_SEL,
    output logic [1:0]  ALU_SEL,
    output logic [1:0]  CIN_SEL,
    output logic [1:0]  RC_SEL,
    output logic [5:0]  OP1,
    output logic [3:0]  state,
    output logic [1:0]  trap_cause
);

    state_e     state_q, state_d;
    logic       phase_q, phase_d;
    logic [1:0] trap_cause_q, trap_cause_d;
    logic [1:0] trap_code;
    logic       in_wait;
    logic       timeout_expired;
    ctrl_t      ctrl;

    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;
    logic       unused_ir;

    assign op  = IR[31:30];
    assign op2 = IR[24:22];
    assign op3 = IR[24:19];
    assign unused_ir = ^{IR[29:25], IR[18:14], IR[12:0]};

    assign in_wait = is_wait_state(state_q);

    // Counter is held clear outside wait states, so every wait starts from zero
    mfc_timeout_counter #(
        .LIMIT (MFC_TIMEOUT)
    ) u_timeout (
        .clk     (Clk),
        .srst    (Reset),
        .clr     (!in_wait),
        .en      (in_wait && !MFC),
        .expired (timeout_expired)
    );

    // Next-state, phase and trap-cause computation
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        trap_cause_d = trap_cause_q;
        trap_code    = TRAP_NONE;
        case (state_q)
            ST_RESET:   state_d = ST_INIT;
            ST_INIT:    state_d = ST_F_ADDR;
            ST_F_ADDR:  state_d = ST_F_WAIT;
            ST_F_WAIT: begin
                // MFC on the final permitted cycle still completes the access
                if (MFC) begin
                    state_d = ST_F_IR;
                end else if (timeout_expired) begin
                    state_d   = ST_TRAP;
                    trap_code = TRAP_MEM_TIMEOUT;
                end
            end
            ST_F_IR:    state_d = ST_DECODE;
            ST_DECODE: begin
                state_d   = ST_TRAP;
                trap_code = TRAP_ILLEGAL;
                case (op)
                    OP_CALL:   state_d = ST_CALL;
                    OP_BRANCH: if (op2 == OP2_BICC) state_d = ST_BRANCH;
                    OP_ARITH:  if (op3 < OP3_ALU_LIMIT) state_d = ST_ALU;
                    OP_MEM:    if (op3 == OP3_LD || op3 == OP3_ST) state_d = ST_LS_ADDR;
                    default:   state_d = ST_TRAP;
                endcase
            end
            ST_ALU:     state_d = ST_ADV;
            ST_LS_ADDR: state_d = (op3 == OP3_LD) ? ST_L_WAIT : ST_S_DATA;
            ST_L_WAIT: begin
                if (MFC) begin
                    state_d = ST_L_WB;
                end else if (timeout_expired) begin
                    state_d   = ST_TRAP;
                    trap_code = TRAP_MEM_TIMEOUT;
                end
            end
            ST_L_WB:    state_d = ST_ADV;
            ST_S_DATA:  state_d = ST_S_WAIT;
            ST_S_WAIT: begin
                if (MFC) begin
                    state_d = ST_ADV;
                end else if (timeout_expired) begin
                    state_d   = ST_TRAP;
                    trap_code = TRAP_MEM_TIMEOUT;
                end
            end
            ST_BRANCH:  state_d = ST_F_ADDR;
            ST_CALL, ST_TRAP: begin
                // Two-cycle states: the phase bit selects the second half
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = ST_F_ADDR;
                end
            end
            ST_ADV:     state_d = ST_F_ADDR;
            default:    state_d = ST_RESET;
        endcase
        if (state_d == ST_TRAP && state_q != ST_TRAP) begin
            trap_cause_d = trap_code;
        end
    end

    // State, phase and sticky trap-cause registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_RESET;
            phase_q      <= 1'b0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Moore decode of the control word, with MFC/IR qualifications
    always_comb begin
        ctrl        = '0;
        ctrl.clr_pc = 1'b1;
        case (state_q)
            ST_RESET: ctrl.clr_pc = 1'b0;
            ST_INIT: begin
                ctrl.npce       = 1'b1;
                ctrl.npc_sel    = NPC_SEL_INC;
                ctrl.npc_add    = 1'b1;
                ctrl.npc_addsel = 1'b1;
            end
            ST_F_ADDR: begin
                ctrl.mare    = 1'b1;
                ctrl.mar_sel = MAR_SEL_PC;
            end
            ST_F_WAIT: begin
                ctrl.mfa     = 1'b1;
                ctrl.mop_sel = OPSEL_OP1;
                ctrl.op1     = OP3_LD;
                ctrl.mdr_sel = MDR_SEL_RAM;
                ctrl.mdre    = MFC;
            end
            ST_F_IR: ctrl.ire = 1'b1;
            ST_ALU: begin
                ctrl.rfe     = 1'b1;
                ctrl.cin_sel = CIN_SEL_ALU;
                ctrl.rc_sel  = RC_SEL_RD;
                ctrl.ra_sel  = RA_SEL_RS1;
                ctrl.aop_sel = OPSEL_IR;
                ctrl.psre    = IR[23];
                ctrl.alu_sel = {1'b0, IR[13]};
            end
            ST_LS_ADDR: begin
                ctrl.mare    = 1'b1;
                ctrl.mar_sel = MAR_SEL_ALU;
                ctrl.aop_sel = OPSEL_OP1;
                ctrl.op1     = OP3_ADD;
                ctrl.alu_sel = {1'b0, IR[13]};
            end
            ST_L_WAIT: begin
                ctrl.mfa     = 1'b1;
                ctrl.mop_sel = OPSEL_IR;
                ctrl.mdr_sel = MDR_SEL_RAM;
                ctrl.mdre    = MFC;
            end
            ST_L_WB: begin
                ctrl.rfe     = 1'b1;
                ctrl.cin_sel = CIN_SEL_MDR;
                ctrl.rc_sel  = RC_SEL_RD;
            end
            ST_S_DATA: begin
                ctrl.ra_sel  = RA_SEL_RD;
                ctrl.mdr_sel = MDR_SEL_RF;
                ctrl.mdre    = 1'b1;
            end
            ST_S_WAIT: begin
                ctrl.mfa     = 1'b1;
                ctrl.mop_sel = OPSEL_IR;
            end
            ST_BRANCH: begin
                ctrl.pce  = 1'b1;
                ctrl.npce = 1'b1;
                if (cond_true) begin
                    ctrl.npc_sel = NPC_SEL_BRANCH;
                    ctrl.baux    = 1'b1;
                end else begin
                    ctrl.npc_sel = NPC_SEL_INC;
                    ctrl.npc_add = 1'b1;
                end
            end
            ST_CALL: begin
                if (!phase_q) begin
                    ctrl.rfe     = 1'b1;
                    ctrl.rc_sel  = RC_SEL_R15;
                    ctrl.cin_sel = CIN_SEL_PC;
                end else begin
                    ctrl.pce     = 1'b1;
                    ctrl.npce    = 1'b1;
                    ctrl.npc_sel = NPC_SEL_BRANCH;
                    ctrl.baux    = 1'b1;
                    ctrl.dispsel = 1'b1;
                end
            end
            ST_ADV: begin
                ctrl.pce     = 1'b1;
                ctrl.npce    = 1'b1;
                ctrl.npc_sel = NPC_SEL_INC;
                ctrl.npc_add = 1'b1;
            end
            ST_TRAP: begin
                if (!phase_q) begin
                    ctrl.tbre  = 1'b1;
                    ctrl.ttaux = 1'b1;
                end else begin
                    ctrl.pce     = 1'b1;
                    ctrl.npce    = 1'b1;
                    ctrl.npc_sel = NPC_SEL_TBR;
                    ctrl.tb_add  = 1'b1;
                end
            end
            default: ctrl.clr_pc = 1'b1;
        endcase
    end

    assign IRE        = ctrl.ire;
    assign MDRE       = ctrl.mdre;
    assign MARE       = ctrl.mare;
    assign nPCE       = ctrl.npce;
    assign PCE        = ctrl.pce;
    assign PSRE       = ctrl.psre;
    assign RFE        = ctrl.rfe;
    assign TBRE       = ctrl.tbre;
    assign WIME       = ctrl.wime;
    assign MFA        = ctrl.mfa;
    assign MOP_SEL    = ctrl.mop_sel;
    assign MAR_SEL    = ctrl.mar_sel;
    assign MDR_SEL    = ctrl.mdr_sel;
    assign RA_SEL     = ctrl.ra_sel;
    assign AOP_SEL    = ctrl.aop_sel;
    assign BAUX       = ctrl.baux;
    assign DISPSEL    = ctrl.dispsel;
    assign nPC_ADD    = ctrl.npc_add;
    assign nPC_ADDSEL = ctrl.npc_addsel;
    assign TB_ADD     = ctrl.tb_add;
    assign ttAUX      = ctrl.ttaux;
    assign ClrPC      = ctrl.clr_pc;
    assign nPC_SEL    = ctrl.npc_sel;
    assign ALU_SEL    = ctrl.alu_sel;
    assign CIN_SEL    = ctrl.cin_sel;
    assign RC_SEL     = ctrl.rc_sel;
    assign OP1        = ctrl.op1;
    assign state      = state_q;
    assign trap_cause = trap_cause_q;

endmodule
